// File: rtl/fp_round_pkg.sv
// Shared rounding types, mode encodings and the round-up decision for the FP result path.
package fp_round_pkg;

  localparam int FRAC_W_DEF = 23;
  localparam int EXP_W_DEF  = 8;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0]  exp;
    logic [FRAC_W_DEF-1:0] frac;
    logic [2:0]            grs;
  } round_req_t;

  // grs = {guard, round, sticky}; lsb is the fraction LSB used for the RNE tie break
  function automatic logic round_up(input rmode_e rm, input logic sign, input logic lsb,
                                    input logic [2:0] grs);
    logic up;
    case (rm)
      RM_RNE:  up = grs[2] & (grs[1] | grs[0] | lsb);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = ~sign & (|grs);
      default: up = sign & (|grs);
    endcase
    return up;
  endfunction

endpackage

// File: rtl/round_arbiter_if.sv
// Request/result bundle of the shared rounding stage: two requesters in, one result out.
interface round_arbiter_if #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 8
);
  logic [1:0]        rmode;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic              req0_sign;
  logic [EXP_W-1:0]  req0_exp;
  logic [FRAC_W-1:0] req0_frac;
  logic [2:0]        req0_grs;
  logic              req1_sign;
  logic [EXP_W-1:0]  req1_exp;
  logic [FRAC_W-1:0] req1_frac;
  logic [2:0]        req1_grs;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [FRAC_W-1:0] out_frac;
  logic              out_src;
  logic              out_inexact;
  logic              out_overflow;

  modport master (
    output rmode, req_valid, req0_sign, req0_exp, req0_frac, req0_grs,
           req1_sign, req1_exp, req1_frac, req1_grs, out_ready,
    input  req_ready, out_valid, out_sign, out_exp, out_frac, out_src,
           out_inexact, out_overflow
  );

  modport slave (
    input  rmode, req_valid, req0_sign, req0_exp, req0_frac, req0_grs,
           req1_sign, req1_exp, req1_frac, req1_grs, out_ready,
    output req_ready, out_valid, out_sign, out_exp, out_frac, out_src,
           out_inexact, out_overflow
  );
endinterface

// File: rtl/frac_round_inc.sv
// Fraction incrementer: adds the round bit and renormalises on carry-out.
module frac_round_inc #(
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              inc_i,
  output logic [FRAC_W-1:0] frac_o,
  output logic              carry_o
);
  logic [FRAC_W-1:0] sum;

  always_comb begin
    {carry_o, sum} = {1'b0, frac_i} + {{FRAC_W{1'b0}}, inc_i};
    // carry only happens from all-ones, so the shifted sum is always zero
    frac_o = carry_o ? {1'b0, sum[FRAC_W-1:1]} : sum;
  end
endmodule

// File: rtl/round_arbiter.sv
// Round-robin shared rounding pipeline: S1 arbitrates and decides round-up, S2 increments.
// Optional inexact statistics counters enabled by defining ROUND_STATS_EN.
module round_arbiter
  import fp_round_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  round_arbiter_if.slave   bus,
  output logic [CNT_W-1:0] inexact_cnt0,
  output logic [CNT_W-1:0] inexact_cnt1
);

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic [2:0]        grs;
    logic              src;
    logic              rnd;
  } s1_t;

  s1_t               req_in, s1_d, s1_q;
  logic              s1_vld_d, s1_vld_q;
  logic              last_grant_d, last_grant_q;
  logic              stall, gnt, xfer;
  logic [1:0]        ready;
  logic [FRAC_W-1:0] inc_frac;
  logic              inc_carry;
  logic [EXP_W-1:0]  exp_inc;

  logic              out_valid_d, out_valid_q;
  logic              out_sign_d, out_sign_q;
  logic [EXP_W-1:0]  out_exp_d, out_exp_q;
  logic [FRAC_W-1:0] out_frac_d, out_frac_q;
  logic              out_src_d, out_src_q;
  logic              out_inexact_d, out_inexact_q;
  logic              out_ovf_d, out_ovf_q;

  // nothing moves while a result sits unaccepted at the output
  assign stall = out_valid_q & ~bus.out_ready;

  always_comb begin
    if (&bus.req_valid) gnt = ~last_grant_q;
    else                gnt = bus.req_valid[1];
    ready = '0;
    if (!stall) ready[gnt] = bus.req_valid[gnt];
    xfer         = |ready;
    last_grant_d = xfer ? gnt : last_grant_q;
  end

  assign bus.req_ready = ready;

  always_comb begin
    req_in      = '0;
    req_in.sign = gnt ? bus.req1_sign : bus.req0_sign;
    req_in.exp  = gnt ? bus.req1_exp  : bus.req0_exp;
    req_in.frac = gnt ? bus.req1_frac : bus.req0_frac;
    req_in.grs  = gnt ? bus.req1_grs  : bus.req0_grs;
    req_in.src  = gnt;
    // inf/NaN pass through untouched
    req_in.rnd  = (&req_in.exp) ? 1'b0
                : round_up(rmode_e'(bus.rmode), req_in.sign, req_in.frac[0], req_in.grs);
    s1_vld_d    = stall ? s1_vld_q : xfer;
    s1_d        = xfer ? req_in : s1_q;
  end

  frac_round_inc #(.FRAC_W(FRAC_W)) u_inc (
    .frac_i  (s1_q.frac),
    .inc_i   (s1_q.rnd),
    .frac_o  (inc_frac),
    .carry_o (inc_carry)
  );

  assign exp_inc = s1_q.exp + 1'b1;

  always_comb begin
    out_valid_d   = stall ? out_valid_q : s1_vld_q;
    out_sign_d    = out_sign_q;
    out_exp_d     = out_exp_q;
    out_frac_d    = out_frac_q;
    out_src_d     = out_src_q;
    out_inexact_d = out_inexact_q;
    out_ovf_d     = out_ovf_q;
    if (!stall && s1_vld_q) begin
      out_sign_d    = s1_q.sign;
      out_exp_d     = inc_carry ? exp_inc : s1_q.exp;
      out_frac_d    = inc_frac;
      out_src_d     = s1_q.src;
      out_inexact_d = |s1_q.grs;
      out_ovf_d     = inc_carry & (&exp_inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q      <= 1'b0;
      s1_q          <= '0;
      last_grant_q  <= 1'b1;
      out_valid_q   <= 1'b0;
      out_sign_q    <= 1'b0;
      out_exp_q     <= '0;
      out_frac_q    <= '0;
      out_src_q     <= 1'b0;
      out_inexact_q <= 1'b0;
      out_ovf_q     <= 1'b0;
    end else begin
      s1_vld_q      <= s1_vld_d;
      s1_q          <= s1_d;
      last_grant_q  <= last_grant_d;
      out_valid_q   <= out_valid_d;
      out_sign_q    <= out_sign_d;
      out_exp_q     <= out_exp_d;
      out_frac_q    <= out_frac_d;
      out_src_q     <= out_src_d;
      out_inexact_q <= out_inexact_d;
      out_ovf_q     <= out_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sign     = out_sign_q;
  assign bus.out_exp      = out_exp_q;
  assign bus.out_frac     = out_frac_q;
  assign bus.out_src      = out_src_q;
  assign bus.out_inexact  = out_inexact_q;
  assign bus.out_overflow = out_ovf_q;

`ifdef ROUND_STATS_EN
  logic [1:0][CNT_W-1:0] cnt_d, cnt_q;

  // saturating per-source count of accepted inexact results
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && bus.out_ready && out_inexact_q && !(&cnt_q[out_src_q]))
      cnt_d[out_src_q] = cnt_q[out_src_q] + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign inexact_cnt0 = cnt_q[0];
  assign inexact_cnt1 = cnt_q[1];
`else
  assign inexact_cnt0 = '0;
  assign inexact_cnt1 = '0;
`endif

endmodule

// File: tb/tb_round_arbiter.sv
// Bench for round_arbiter: vector table, arbitration/stall/reset sequences, random scoreboard.
module tb_round_arbiter;
  import fp_round_pkg::*;

  localparam int FW = 23;
  localparam int EW = 8;
  localparam int CW = 2;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [FW-1:0] frac;
    logic          src;
    logic          inexact;
    logic          ovf;
  } res_t;

  typedef struct {
    logic [1:0] rm;
    round_req_t rq;
    res_t       ex;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] cnt0, cnt1;

  round_arbiter_if #(.FRAC_W(FW), .EXP_W(EW)) bus ();

  round_arbiter #(.FRAC_W(FW), .EXP_W(EW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .inexact_cnt0 (cnt0),
    .inexact_cnt1 (cnt1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];
  logic mlast = 1'b1;
  bit   prev_stall = 1'b0;
  res_t prev_out;
  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic res_t cur_out();
    return {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_src, bus.out_inexact, bus.out_overflow};
  endfunction

  // reference: round the value as a number, then renormalise if it reached 2^FW
  function automatic res_t ref_round(input logic [1:0] rm, input round_req_t r, input logic src);
    res_t   o;
    int     up, e;
    longint m;
    up = 0;
    if (r.exp != 8'hFF && r.grs != 3'b000) begin
      case (rm)
        2'b00:   up = (r.grs[2] && (r.grs[1] || r.grs[0] || r.frac[0])) ? 1 : 0;
        2'b01:   up = 0;
        2'b10:   up = r.sign ? 0 : 1;
        default: up = r.sign ? 1 : 0;
      endcase
    end
    m = longint'(r.frac) + longint'(up);
    o.sign    = r.sign;
    o.src     = src;
    o.inexact = (r.grs != 3'b000);
    o.ovf     = 1'b0;
    if (m >= (longint'(1) << FW)) begin
      e      = int'(r.exp) + 1;
      o.frac = '0;
      o.exp  = e[EW-1:0];
      o.ovf  = (e == (1 << EW) - 1);
    end else begin
      o.frac = m[FW-1:0];
      o.exp  = r.exp;
    end
    return o;
  endfunction

  function automatic vec_t mk(input logic [1:0] rm, input logic s, input logic [7:0] e,
                              input logic [22:0] f, input logic [2:0] g, input logic [7:0] ee,
                              input logic [22:0] ef, input logic einx, input logic eovf);
    vec_t v;
    v.rm = rm;
    v.rq = '{sign: s, exp: e, frac: f, grs: g};
    v.ex = '{sign: s, exp: ee, frac: ef, src: 1'b0, inexact: einx, ovf: eovf};
    return v;
  endfunction

  function automatic round_req_t rnd_req();
    round_req_t r;
    r.sign = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       r.exp = 8'hFE;
      1:       r.exp = 8'hFF;
      default: r.exp = 8'($urandom);
    endcase
    r.frac = ($urandom_range(0, 2) == 0) ? 23'h7FFFFF : 23'($urandom);
    r.grs  = 3'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic drive_req(input logic i, input round_req_t r);
    if (i) begin
      bus.req1_sign = r.sign; bus.req1_exp = r.exp; bus.req1_frac = r.frac; bus.req1_grs = r.grs;
    end else begin
      bus.req0_sign = r.sign; bus.req0_exp = r.exp; bus.req0_frac = r.frac; bus.req0_grs = r.grs;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    exp_q.delete();
    mlast = 1'b1;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one cycle of traffic checked against the scoreboard and the arbitration model
  task automatic cycle(input logic [1:0] v, input bit ordy);
    round_req_t r0, r1;
    logic [1:0] er;
    logic       g;
    bit         st;
    res_t       co, e;
    r0 = rnd_req();
    r1 = rnd_req();
    @(negedge clk);
    bus.rmode = 2'($urandom_range(0, 3));
    drive_req(1'b0, r0);
    drive_req(1'b1, r1);
    bus.req_valid = v;
    bus.out_ready = ordy;
    #1;
    co = cur_out();
    if (prev_stall) chk("stall_hold", co, prev_out);
    st = bus.out_valid & ~ordy;
    g  = (v == 2'b11) ? ~mlast : v[1];
    er = 2'b00;
    if (!st && v[g]) er[g] = 1'b1;
    chk("req_ready", bus.req_ready, er);
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out got=%0h exp=none", co);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", co, e);
      end
    end
    if (er != 2'b00) begin
      exp_q.push_back(ref_round(bus.rmode, g ? r1 : r0, g));
      mlast = g;
    end
    prev_stall = st;
    prev_out   = co;
  endtask

  task automatic apply_one(input logic [1:0] rm, input round_req_t r, input logic src,
                           output res_t got);
    @(negedge clk);
    bus.rmode = rm;
    drive_req(src, r);
    bus.req_valid = src ? 2'b10 : 2'b01;
    bus.out_ready = 1'b1;
    #1;
    chk("vec_ready", bus.req_ready, src ? 2'b10 : 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.rmode = rm ^ 2'b01;   // in-flight result must ignore this
    drive_req(src, rnd_req());
    chk("vec_lat1", bus.out_valid, 0);
    @(negedge clk);
    chk("vec_lat2", bus.out_valid, 1);
    got = cur_out();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t       got, e;
    int         srcs[$];
    int         burst;
    round_req_t rq;

    bus.rmode = 2'b00; bus.req_valid = 2'b00; bus.out_ready = 1'b0;
    drive_req(1'b0, '0);
    drive_req(1'b1, '0);
    #1;
    chk("rst_out", cur_out(), '0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_cnt", {cnt0, cnt1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vt[0]  = mk(2'b00, 0, 8'h80, 23'h000001, 3'b100, 8'h80, 23'h000002, 1, 0);
    vt[1]  = mk(2'b00, 0, 8'h80, 23'h000002, 3'b100, 8'h80, 23'h000002, 1, 0);
    vt[2]  = mk(2'b10, 0, 8'h7F, 23'h7FFFFF, 3'b001, 8'h80, 23'h000000, 1, 0);
    vt[3]  = mk(2'b00, 0, 8'hFE, 23'h7FFFFF, 3'b110, 8'hFF, 23'h000000, 1, 1);
    vt[4]  = mk(2'b00, 0, 8'hFF, 23'h123456, 3'b111, 8'hFF, 23'h123456, 1, 0);
    vt[5]  = mk(2'b01, 0, 8'h10, 23'h7FFFFF, 3'b111, 8'h10, 23'h7FFFFF, 1, 0);
    vt[6]  = mk(2'b11, 1, 8'h20, 23'h000005, 3'b010, 8'h20, 23'h000006, 1, 0);
    vt[7]  = mk(2'b11, 0, 8'h20, 23'h000005, 3'b010, 8'h20, 23'h000005, 1, 0);
    vt[8]  = mk(2'b10, 1, 8'h20, 23'h000005, 3'b100, 8'h20, 23'h000005, 1, 0);
    vt[9]  = mk(2'b00, 0, 8'h33, 23'h000003, 3'b000, 8'h33, 23'h000003, 0, 0);
    vt[10] = mk(2'b00, 1, 8'h33, 23'h000004, 3'b101, 8'h33, 23'h000005, 1, 0);
    vt[11] = mk(2'b00, 0, 8'h33, 23'h000007, 3'b011, 8'h33, 23'h000007, 1, 0);
    vt[12] = mk(2'b11, 1, 8'hFF, 23'h7FFFFF, 3'b111, 8'hFF, 23'h7FFFFF, 1, 0);
    vt[13] = mk(2'b00, 0, 8'h7E, 23'h7FFFFF, 3'b100, 8'h7F, 23'h000000, 1, 0);
    vt[14] = mk(2'b10, 0, 8'h01, 23'h7FFFFE, 3'b001, 8'h01, 23'h7FFFFF, 1, 0);

    for (int i = 0; i < 15; i++) begin
      apply_one(vt[i].rm, vt[i].rq, 1'(i % 2), got);
      e = vt[i].ex;
      e.src = 1'(i % 2);
      chk($sformatf("vec%0d", i), got, e);
    end

    // both requesters held valid: grants alternate starting with requester 0
    do_reset();
    rq = '{sign: 1'b0, exp: 8'h40, frac: 23'h000010, grs: 3'b000};
    drive_req(1'b0, rq);
    drive_req(1'b1, rq);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.req_valid = (c < 6) ? 2'b11 : 2'b00;
      bus.out_ready = 1'b1;
      #1;
      if (c < 6) chk("alt_grant", bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (bus.out_valid) srcs.push_back(int'(bus.out_src));
    end
    chk("alt_count", srcs.size(), 6);
    for (int k = 0; k < srcs.size(); k++) chk("alt_src", srcs[k], k % 2);

    // output stall with both requesters pushing
    do_reset();
    repeat (2) cycle(2'b11, 1'b1);
    repeat (5) cycle(2'b11, 1'b0);
    repeat (5) cycle(2'b00, 1'b1);
    chk("stall_drain", exp_q.size(), 0);

    // reset with the pipe full
    repeat (3) cycle(2'b11, 1'b1);
    chk("rst_pre_valid", bus.out_valid, 1);
    do_reset();
    #1;
    chk("rst_post_valid", bus.out_valid, 0);

    burst = 0;
    for (int n = 0; n < 1500; n++) begin
      bit ordy;
      if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 6);
      if (burst > 0) begin
        ordy = 1'b0;
        burst--;
      end else begin
        ordy = ($urandom_range(0, 3) != 0);
      end
      cycle(2'($urandom_range(0, 3)), ordy);
      if (n == 700) do_reset();
    end
    repeat (4) cycle(2'b00, 1'b1);
    chk("rand_drain", exp_q.size(), 0);

    // statistics counters: 3 inexact + 1 exact from requester 1, then saturation
    do_reset();
    rq = '{sign: 1'b0, exp: 8'h50, frac: 23'h000100, grs: 3'b100};
    repeat (3) apply_one(2'b00, rq, 1'b1, got);
    rq.grs = 3'b000;
    apply_one(2'b00, rq, 1'b1, got);
    @(negedge clk);
`ifdef ROUND_STATS_EN
    chk("cnt1", cnt1, 3);
    chk("cnt0", cnt0, 0);
    rq.grs = 3'b011;
    repeat (2) apply_one(2'b01, rq, 1'b1, got);
    @(negedge clk);
    chk("cnt1_sat", cnt1, 3);
`else
    chk("cnt1_off", cnt1, 0);
    chk("cnt0_off", cnt0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_arbiter.md
Name: round_arbiter

Overview:
Two-stage pipelined scheduler that shares one fraction-rounding incrementer between two result producers (requester 0 = add/sub path, requester 1 = mul path). It arbitrates round-robin and computes the round-up decision from guard/round/sticky bits and the rounding mode. It applies the increment with carry-out renormalisation and exponent adjust, then delivers a packed rounded result over a valid/ready handshake. It sits between the normalisation stages and the result writeback.

Parameters:
FRAC_W, 23, fraction width (hidden bit excluded)
EXP_W, 8, biased exponent width
CNT_W, 16, statistics counter width (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rmode  input  2  rounding mode: 00 RNE, 01 RTZ, 10 toward +inf, 11 toward -inf
req_valid  input  2  per-requester request valid
req_ready  output  2  per-requester accept; transfer when req_valid[i] & req_ready[i]
req0_sign / req1_sign  input  1  sign
req0_exp / req1_exp  input  EXP_W  biased exponent
req0_frac / req1_frac  input  FRAC_W  unrounded fraction
req0_grs / req1_grs  input  3  {guard, round, sticky}
out_valid  output  1  result valid
out_ready  input  1  downstream accept
out_sign  output  1  result sign
out_exp  output  EXP_W  rounded exponent
out_frac  output  FRAC_W  rounded fraction
out_src  output  1  requester id of this result
out_inexact  output  1  grs != 0 on the input
out_overflow  output  1  rounding carried exponent to all-ones
inexact_cnt0 / inexact_cnt1  output  CNT_W  inexact counts (optional feature)

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. All flops clear on rst_n low: stage valids 0, last_grant=1 (requester 0 wins first tie), all out_* 0.
- Arbitration:
  - Exactly one requester is granted per cycle, and only when stage 1 can load (S1 empty, or S1 advancing this cycle).
  - Only one valid: grant it. Both valid: grant ~last_grant. last_grant updates only on an actual transfer.
  - req_ready is combinational from req_valid, last_grant and the stall; it is never asserted for a non-granted requester.
- Stage 1 (registered on transfer):
  - Captures sign, exp, frac, grs, src and rmode.
  - Computes rnd: RNE = G&(R|S|frac[0]); RTZ = 0; +inf = ~sign&(|grs); -inf = sign&(|grs).
  - exp == all-ones (inf/NaN): rnd forced 0, value passes through unchanged.
- Stage 2 (registered):
  - {carry, sum} = frac + rnd.
  - carry=1: out_frac = {0, sum[FRAC_W-1:1]}, which is 0; out_exp = exp+1.
  - carry=0: out_frac = sum, out_exp = exp.
  - out_overflow = carry & (exp+1 == all-ones); the result is then inf with out_frac = 0.
  - out_inexact = |grs.
- Pipeline control:
  - Latency is 2 cycles from transfer to out_valid with no stall; throughput is 1 per cycle.
  - Stall when out_valid & ~out_ready: S2 holds, S1 holds if full, req_ready = 0.
  - out_* are stable while out_valid & ~out_ready.
- Corner cases:
  - rmode changes mid-flight: affects only newly accepted requests.
  - Reset mid-operation: in-flight results are discarded.

Optional Feature:
ROUND_STATS_EN
- Defined: two CNT_W counters increment when a stage-2 result with out_inexact=1 is accepted (out_valid & out_ready), selected by out_src. Counters saturate at all-ones and reset to 0.
- Undefined: no counter flops; inexact_cnt0/1 are tied to 0.

Decomposition:
- Shared package fp_round_pkg holds:
  - FRAC_W and EXP_W defaults.
  - Rounding-mode encodings RM_RNE=2'b00, RM_RTZ=2'b01, RM_RUP=2'b10, RM_RDN=2'b11.
  - Struct round_req_t {sign, exp, frac, grs}.
- One sub-module, frac_round_inc: a combinational FRAC_W incrementer producing the renormalised fraction and the carry, instantiated in stage 2.

Test Plan:
- Only req0 valid, RNE, exp=0x80, frac=0x000001, grs=100 → after 2 cycles out_frac=0x000002, out_exp=0x80, out_inexact=1, out_src=0.
- RNE tie to even: frac=0x000002, grs=100 → out_frac=0x000002. +inf mode, sign=0, frac=0x7FFFFF, exp=0x7F, grs=001 → out_frac=0, out_exp=0x80.
- Overflow: exp=0xFE, frac=0x7FFFFF, grs=110, RNE → out_exp=0xFF, out_frac=0, out_overflow=1. Input exp=0xFF, grs=111 → passes unchanged.
- Both requesters valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1; out_src matches the grant order.
- Hold out_ready=0 for 5 cycles with both valid → req_ready=0 after the pipe fills, out_* stable, no loss or duplication after release. Assert rst_n low mid-stream → out_valid=0 immediately.
- With ROUND_STATS_EN: 3 inexact results from req1 and 1 exact → inexact_cnt1=3, inexact_cnt0=0. Preload to all-ones → count saturates.
